// File: rtl/mult_share_arb.sv
// Round-robin arbiter that shares one iterative start/busy multiplier
// between two requesters: squaring path (port 0) and cube-root unit (port 1).
// It serialises requests, issues a one-cycle start pulse, watches the
// multiplier busy flag and returns the product with a per-port done pulse.
module mult_share_arb #(
  parameter int W           = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [W-1:0]   op_a0,
  input  logic [W-1:0]   op_b0,
  input  logic [W-1:0]   op_a1,
  input  logic [W-1:0]   op_b1,
  output logic [1:0]     done,
  output logic [2*W-1:0] result,
  output logic           err,
  output logic           busy_o,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_busy,
  input  logic [2*W-1:0] mul_f
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t          state_q;
  logic            grant_q;
  logic            grant_d;
  logic            last_grant_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic [1:0]      done_q;
  logic [2*W-1:0]  result_q;
  logic            err_q;
  logic            busy_q;
  logic            start_q;
  logic [W-1:0]    mul_a_q;
  logic [W-1:0]    mul_b_q;

  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy_o    = busy_q;
  assign mul_start = start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  assign cnt_inc = cnt_q + 1'b1;

  // Grant selection: a lone requester wins; on a tie the port that did not
  // win last time is served, so back-to-back ties alternate.
  always_comb begin
    grant_d = req[1] & (~req[0] | ~last_grant_q);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      done_q       <= 2'b00;
      result_q     <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            grant_q <= grant_d;
            mul_a_q <= grant_d ? op_a1 : op_a0;
            mul_b_q <= grant_d ? op_b1 : op_b0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (mul_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_inc == CW'(ACK_TIMEOUT - 1)) begin
            // Multiplier never acknowledged the start: report a zero result.
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= grant_q ? 2'b10 : 2'b01;
            state_q  <= S_RESPOND;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (!mul_busy) begin
            result_q <= mul_f;
            done_q   <= grant_q ? 2'b10 : 2'b01;
            state_q  <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          // Requests are ignored here so the winner has a cycle to drop req.
          done_q       <= 2'b00;
          err_q        <= 1'b0;
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
